// File: rtl/dsi_lane_scheduler_if.sv
// ---------------------------------------------------------------------------
// dsi_lane_scheduler_if
// Bundles the pixel stream, the DCS command stream and the serializer word
// output of the DSI lane scheduler.
//   pix_valid/pix_data/pix_ready : RGB888 pixel source handshake
//   cmd_valid/cmd_data/cmd_ready : DCS command source handshake
//   ser_load/ser_data            : one word per slot to the serializer
//   line_start/frame_start       : timing markers aligned with ser_load
// The slave modport is the scheduler; the master modport is the side that
// owns the sources and the serializer.
// ---------------------------------------------------------------------------
interface dsi_lane_scheduler_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic        cmd_valid;
    logic [23:0] cmd_data;
    logic        cmd_ready;
    logic        ser_load;
    logic [23:0] ser_data;
    logic        line_start;
    logic        frame_start;

    modport master (
        output pix_valid, pix_data, cmd_valid, cmd_data,
        input  pix_ready, cmd_ready, ser_load, ser_data, line_start, frame_start
    );

    modport slave (
        input  pix_valid, pix_data, cmd_valid, cmd_data,
        output pix_ready, cmd_ready, ser_load, ser_data, line_start, frame_start
    );
endinterface

// File: rtl/dsi_lane_scheduler.sv
// ---------------------------------------------------------------------------
// dsi_lane_scheduler
// Shares the single serializer lane between the video pixel stream and the
// DCS command stream. Generates frame/line timing in units of word slots and
// decides, once per slot, which word the serializer loads: pixels in the
// active region, commands or filler in blanking.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   enable_i         : run request, only acted on at frame boundaries
//   underrun_clr_i   : clears the sticky underrun flag
//   underrun_o       : sticky, an active slot found no pixel available
//   bus (slave)      : pixel/command handshakes and serializer outputs
// ---------------------------------------------------------------------------
module dsi_lane_scheduler #(
    parameter int unsigned WORD_CYCLES   = 24,
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_BLANK       = 160,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_BLANK       = 45,
    parameter int unsigned CMD_MAX_BURST = 4,
    parameter logic [23:0] FILL_WORD     = 24'h0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic underrun_clr_i,
    output logic underrun_o,
    dsi_lane_scheduler_if.slave bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int unsigned SLOT_W  = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
    localparam int unsigned H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned B_W     = (CMD_MAX_BURST > 0) ? $clog2(CMD_MAX_BURST + 1) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORD_CYCLES - 1);
    localparam logic [H_W-1:0]    H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT     = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]    V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_ACT     = V_W'(V_ACTIVE);
    localparam logic [B_W-1:0]    B_MAX     = B_W'(CMD_MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_e;

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [H_W-1:0]    h_q, h_d;
    logic [V_W-1:0]    v_q, v_d;
    logic [B_W-1:0]    burst_q, burst_d;

    logic              slot_wrap;
    logic              h_wrap;
    logic              frame_end;

    logic              decision;
    logic              pix_ready;
    logic              cmd_ready;
    logic              cmd_accept;
    logic              pix_miss;
    logic [23:0]       word_sel;

    logic              ser_load_q;
    logic [23:0]       ser_data_q;
    logic              line_start_q;
    logic              frame_start_q;
    logic              underrun_q;

    // State register: scheduler state plus the slot/h/v position and the
    // per-blanking-interval command counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            h_q     <= '0;
            v_q     <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            h_q     <= h_d;
            v_q     <= v_d;
            burst_q <= burst_d;
        end
    end

    // Next-state logic. The position advances slot by slot; the region
    // (ACTIVE/HBLANK/VBLANK) is recomputed from the new h/v at each slot
    // wrap. enable_i only matters in IDLE and at the very last slot of a
    // frame. The burst counter restarts whenever a new blanking interval
    // begins, and every VBLANK line counts as its own interval.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        h_d       = h_q;
        v_d       = v_q;
        burst_d   = burst_q;
        slot_wrap = (slot_q == SLOT_LAST);
        h_wrap    = slot_wrap && (h_q == H_LAST);
        frame_end = h_wrap && (v_q == V_LAST);

        case (state_q)
            IDLE: begin
                slot_d  = '0;
                h_d     = '0;
                v_d     = '0;
                burst_d = '0;
                if (enable_i) begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                if (cmd_accept) begin
                    burst_d = burst_q + B_W'(1);
                end
                slot_d = slot_wrap ? '0 : slot_q + SLOT_W'(1);
                if (slot_wrap) begin
                    h_d = h_wrap ? '0 : h_q + H_W'(1);
                    if (h_wrap) begin
                        v_d = frame_end ? '0 : v_q + V_W'(1);
                    end
                    if (frame_end && !enable_i) begin
                        state_d = IDLE;
                    end else if (v_d >= V_ACT) begin
                        state_d = VBLANK;
                    end else if (h_d >= H_ACT) begin
                        state_d = HBLANK;
                    end else begin
                        state_d = ACTIVE;
                    end
                    if ((state_d != state_q) || ((state_d == VBLANK) && h_wrap)) begin
                        burst_d = '0;
                    end
                end
            end
        endcase
    end

    // Output decode for the slot==0 decision cycle. Readies depend only on
    // the schedule, never on the valids, so sources see a stable grant.
    always_comb begin
        decision   = (state_q != IDLE) && (slot_q == '0);
        pix_ready  = (state_q == ACTIVE) && (slot_q == '0);
        cmd_ready  = ((state_q == HBLANK) || (state_q == VBLANK)) &&
                     (slot_q == '0) && (burst_q < B_MAX);
        cmd_accept = cmd_ready && bus.cmd_valid;
        pix_miss   = pix_ready && !bus.pix_valid;
        word_sel   = FILL_WORD;
        if (pix_ready && bus.pix_valid) begin
            word_sel = bus.pix_data;
        end else if (cmd_accept) begin
            word_sel = bus.cmd_data;
        end
    end

    // Serializer-side registers. Everything launched from the decision
    // cycle lands together one cycle later so line/frame markers stay
    // aligned with ser_load. ser_data keeps the last word between loads.
    // A fresh underrun takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_load_q    <= 1'b0;
            ser_data_q    <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            ser_load_q    <= decision;
            line_start_q  <= decision && (h_q == '0);
            frame_start_q <= decision && (h_q == '0) && (v_q == '0);
            if (decision) begin
                ser_data_q <= word_sel;
            end
            if (pix_miss) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr_i) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign bus.pix_ready   = pix_ready;
    assign bus.cmd_ready   = cmd_ready;
    assign bus.ser_load    = ser_load_q;
    assign bus.ser_data    = ser_data_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_dsi_lane_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dsi_lane_scheduler
// Directed bench for the DSI lane scheduler with a tiny 6x3-slot frame
// (4 active + 2 blanking slots per line, 2 active + 1 blanking line).
// Two full frames run from a table of per-slot records; the underrun clear,
// enable drop, re-enable and asynchronous reset cases are hand sequences.
// ---------------------------------------------------------------------------
module tb_dsi_lane_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic underrun_clr = 1'b0;
    logic underrun;

    int assertCount = 0;
    int failCount = 0;
    logic lastPixReady = 1'b0;
    logic lastCmdReady = 1'b0;

    dsi_lane_scheduler_if bus ();

    dsi_lane_scheduler #(
        .WORD_CYCLES  (4),
        .H_ACTIVE     (4),
        .H_BLANK      (2),
        .V_ACTIVE     (2),
        .V_BLANK      (1),
        .CMD_MAX_BURST(1),
        .FILL_WORD    (24'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .underrun_clr_i(underrun_clr),
        .underrun_o    (underrun),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pixValid;
        logic [23:0] pixData;
        logic        cmdValid;
        logic [23:0] cmdData;
        logic [23:0] expData;
        logic        expLine;
        logic        expFrame;
        logic        expPixReady;
        logic        expCmdReady;
        logic        expUnderrun;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic pv, input logic [23:0] pd,
                                   input logic cv, input logic [23:0] cd,
                                   input logic [23:0] ed, input logic el,
                                   input logic ef, input logic epr,
                                   input logic ecr, input logic eur);
        vec_t v;
        v.pixValid = pv; v.pixData = pd; v.cmdValid = cv; v.cmdData = cd;
        v.expData = ed; v.expLine = el; v.expFrame = ef;
        v.expPixReady = epr; v.expCmdReady = ecr; v.expUnderrun = eur;
        vecs.push_back(v);
    endfunction

    // One record per slot; columns: pv pd cv cd | data line frame pixRdy cmdRdy underrun
    task automatic buildTable();
        // Frame 1: pixels 1..8, command source always valid
        addVec(1, 24'h000001, 1, 24'hABCDEF, 24'h000001, 1, 1, 1, 0, 0);
        addVec(1, 24'h000002, 1, 24'hABCDEF, 24'h000002, 0, 0, 1, 0, 0);
        addVec(1, 24'h000003, 1, 24'hABCDEF, 24'h000003, 0, 0, 1, 0, 0);
        addVec(1, 24'h000004, 1, 24'hABCDEF, 24'h000004, 0, 0, 1, 0, 0);
        addVec(1, 24'h777777, 1, 24'hABCDEF, 24'hABCDEF, 0, 0, 0, 1, 0);
        addVec(1, 24'h777777, 1, 24'hABCDEF, 24'h000000, 0, 0, 0, 0, 0);
        addVec(1, 24'h000005, 1, 24'hABCDEF, 24'h000005, 1, 0, 1, 0, 0);
        addVec(1, 24'h000006, 1, 24'hABCDEF, 24'h000006, 0, 0, 1, 0, 0);
        addVec(1, 24'h000007, 1, 24'hABCDEF, 24'h000007, 0, 0, 1, 0, 0);
        addVec(1, 24'h000008, 1, 24'hABCDEF, 24'h000008, 0, 0, 1, 0, 0);
        addVec(1, 24'h777777, 1, 24'hABCDEF, 24'hABCDEF, 0, 0, 0, 1, 0);
        addVec(1, 24'h777777, 1, 24'hABCDEF, 24'h000000, 0, 0, 0, 0, 0);
        addVec(1, 24'h777777, 1, 24'hABCDEF, 24'hABCDEF, 1, 0, 0, 1, 0);
        addVec(1, 24'h777777, 1, 24'hABCDEF, 24'h000000, 0, 0, 0, 0, 0);
        addVec(1, 24'h777777, 1, 24'hABCDEF, 24'h000000, 0, 0, 0, 0, 0);
        addVec(0, 24'h777777, 1, 24'hABCDEF, 24'h000000, 0, 0, 0, 0, 0);
        addVec(1, 24'h777777, 1, 24'hABCDEF, 24'h000000, 0, 0, 0, 0, 0);
        addVec(1, 24'h777777, 1, 24'hABCDEF, 24'h000000, 0, 0, 0, 0, 0);
        // Frame 2: underrun at line 0 h=2, late commands inside intervals
        addVec(1, 24'h000011, 0, 24'h000000, 24'h000011, 1, 1, 1, 0, 0);
        addVec(1, 24'h000012, 0, 24'h000000, 24'h000012, 0, 0, 1, 0, 0);
        addVec(0, 24'h000099, 0, 24'h000000, 24'h000000, 0, 0, 1, 0, 1);
        addVec(1, 24'h000013, 0, 24'h000000, 24'h000013, 0, 0, 1, 0, 1);
        addVec(1, 24'h777777, 0, 24'hABCDEF, 24'h000000, 0, 0, 0, 1, 1);
        addVec(1, 24'h777777, 1, 24'h123456, 24'h123456, 0, 0, 0, 1, 1);
        addVec(1, 24'h000014, 0, 24'h000000, 24'h000014, 1, 0, 1, 0, 1);
        addVec(1, 24'h000015, 0, 24'h000000, 24'h000015, 0, 0, 1, 0, 1);
        addVec(1, 24'h000016, 0, 24'h000000, 24'h000016, 0, 0, 1, 0, 1);
        addVec(1, 24'h000017, 0, 24'h000000, 24'h000017, 0, 0, 1, 0, 1);
        addVec(1, 24'h777777, 1, 24'h654321, 24'h654321, 0, 0, 0, 1, 1);
        addVec(1, 24'h777777, 1, 24'h654321, 24'h000000, 0, 0, 0, 0, 1);
        addVec(0, 24'h777777, 0, 24'hABCDEF, 24'h000000, 1, 0, 0, 1, 1);
        addVec(0, 24'h777777, 1, 24'h0000AA, 24'h0000AA, 0, 0, 0, 1, 1);
        addVec(0, 24'h777777, 1, 24'h0000BB, 24'h000000, 0, 0, 0, 0, 1);
        addVec(0, 24'h777777, 1, 24'h0000BB, 24'h000000, 0, 0, 0, 0, 1);
        addVec(0, 24'h777777, 1, 24'h0000BB, 24'h000000, 0, 0, 0, 0, 1);
        addVec(0, 24'h777777, 1, 24'h0000BB, 24'h000000, 0, 0, 0, 0, 1);
    endtask

    task automatic checkOutput(input string name, input logic [23:0] actual,
                               input logic [23:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.pix_valid = v.pixValid;
        bus.pix_data  = v.pixData;
        bus.cmd_valid = v.cmdValid;
        bus.cmd_data  = v.cmdData;
    endtask

    // Waits (bounded) for the next ser_load at a falling edge; the readies
    // seen on the cycle before the load are kept for checking.
    task automatic waitLoad(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 24 && !got; i++) begin
            @(negedge clk);
            if (bus.ser_load === 1'b1) begin
                got = 1'b1;
            end else begin
                lastPixReady = bus.pix_ready;
                lastCmdReady = bus.cmd_ready;
            end
        end
        checkOutput({name, " load arrived"}, got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int loadCount;
        int readyCount;

        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        buildTable();

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset ser_load", bus.ser_load, 0);
        checkOutput("reset ser_data", bus.ser_data, 0);
        checkOutput("reset line_start", bus.line_start, 0);
        checkOutput("reset frame_start", bus.frame_start, 0);
        checkOutput("reset pix_ready", bus.pix_ready, 0);
        checkOutput("reset cmd_ready", bus.cmd_ready, 0);
        checkOutput("reset underrun", underrun, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two back-to-back frames from the table
        applyStimulus(vecs[0]);
        enable = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            waitLoad($sformatf("row %0d", i));
            checkOutput($sformatf("row %0d ser_data", i), bus.ser_data, vecs[i].expData);
            checkOutput($sformatf("row %0d line_start", i), bus.line_start, vecs[i].expLine);
            checkOutput($sformatf("row %0d frame_start", i), bus.frame_start, vecs[i].expFrame);
            checkOutput($sformatf("row %0d pix_ready", i), lastPixReady, vecs[i].expPixReady);
            checkOutput($sformatf("row %0d cmd_ready", i), lastCmdReady, vecs[i].expCmdReady);
            checkOutput($sformatf("row %0d underrun", i), underrun, vecs[i].expUnderrun);
            if (i + 1 < vecs.size()) begin
                applyStimulus(vecs[i + 1]);
            end
        end

        // Underrun clear outside a decision cycle, then frame 3 slot 0
        bus.pix_valid = 1'b1;
        bus.pix_data  = 24'h000021;
        bus.cmd_valid = 1'b0;
        underrun_clr  = 1'b1;
        @(negedge clk);
        underrun_clr  = 1'b0;
        checkOutput("underrun cleared", underrun, 0);
        waitLoad("frame3 h0");
        checkOutput("frame3 h0 ser_data", bus.ser_data, 24'h000021);
        checkOutput("frame3 h0 frame_start", bus.frame_start, 1);

        // Clear coincident with a new underrun: the underrun wins
        bus.pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("frame3 h1 decision pix_ready", bus.pix_ready, 1);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        checkOutput("frame3 h1 ser_load", bus.ser_load, 1);
        checkOutput("frame3 h1 ser_data", bus.ser_data, 24'h000000);
        checkOutput("same-cycle clr underrun", underrun, 1);

        // Drop enable at v=0,h=1: the frame must still run to completion
        enable = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 24'h000022;
        underrun_clr  = 1'b1;
        @(negedge clk);
        underrun_clr  = 1'b0;
        checkOutput("underrun cleared again", underrun, 0);
        loadCount = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.ser_load === 1'b1) loadCount++;
        end
        checkOutput("loads after enable drop", 24'(loadCount), 24'd16);
        checkOutput("idle pix_ready", bus.pix_ready, 0);
        checkOutput("idle ser_load", bus.ser_load, 0);

        // Re-enable restarts with frame_start
        bus.pix_data = 24'h000031;
        enable = 1'b1;
        waitLoad("restart");
        checkOutput("restart ser_data", bus.ser_data, 24'h000031);
        checkOutput("restart frame_start", bus.frame_start, 1);
        checkOutput("restart line_start", bus.line_start, 1);
        checkOutput("restart pix_ready", lastPixReady, 1);

        // Asynchronous reset while outputs are high
        rst_n = 1'b0;
        #1;
        checkOutput("async reset ser_load", bus.ser_load, 0);
        checkOutput("async reset ser_data", bus.ser_data, 0);
        checkOutput("async reset frame_start", bus.frame_start, 0);
        checkOutput("async reset line_start", bus.line_start, 0);
        checkOutput("async reset pix_ready", bus.pix_ready, 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        loadCount = 0;
        readyCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ser_load === 1'b1) loadCount++;
            if (bus.pix_ready === 1'b1) readyCount++;
        end
        checkOutput("post-reset idle loads", 24'(loadCount), 24'd0);
        checkOutput("post-reset idle readies", 24'(readyCount), 24'd0);
        bus.pix_data = 24'h000041;
        enable = 1'b1;
        waitLoad("post-reset start");
        checkOutput("post-reset ser_data", bus.ser_data, 24'h000041);
        checkOutput("post-reset frame_start", bus.frame_start, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
